// File: rtl/mlaccel_sequencer_gen2.sv
// Instruction sequencer: fetch with call/return/jump resolution, instruction FIFO,
// execute-count expansion and a registered valid/ready compute port.
// Optional feature macro: MLACCEL_SEQ_STATS_EN adds the stat_issued handshake counter.
module mlaccel_sequencer_gen2 #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned QUEUE_LOG2   = 9,
    parameter int unsigned STACK_LOG2   = 9,
    parameter int unsigned QUEUE_MARGIN = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              error,
    output logic              smem_valid,
    input  logic              smem_ready,
    output logic [ADDR_W-1:0] smem_addr,
    input  logic [31:0]       smem_data,
    output logic              comp_valid,
    input  logic              comp_ready,
    output logic [31:0]       comp_data
`ifdef MLACCEL_SEQ_STATS_EN
    ,
    output logic [31:0]       stat_issued
`endif
);

    localparam int unsigned QUEUE_DEPTH = 2 ** QUEUE_LOG2;
    localparam int unsigned STACK_DEPTH = 2 ** STACK_LOG2;
    localparam int unsigned QUEUE_LIMIT = QUEUE_DEPTH - QUEUE_MARGIN;
    localparam int unsigned QPTR_W      = QUEUE_LOG2 + 1;
    localparam int unsigned SPTR_W      = STACK_LOG2 + 1;

    localparam logic [5:0] OP_CALL = 6'd1;
    localparam logic [5:0] OP_RET  = 6'd2;
    localparam logic [5:0] OP_EXEC = 6'd3;
    localparam logic [5:0] OP_JUMP = 6'd4;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]     pc;
    logic [ADDR_W-1:0]     stack_mem [STACK_DEPTH];
    logic [SPTR_W-1:0]     sp;
    logic [31:0]           q_mem [QUEUE_DEPTH];
    logic [QPTR_W-1:0]     wr_ptr, rd_ptr, q_count;
    logic                  queue_full;
    logic [31:0]           buf_insn;
    logic                  buf_valid;

    logic                  flush, running;
    logic                  rsp_fire, is_call, is_ret, is_jump, enq;
    logic                  stack_full, stack_empty;
    logic [ADDR_W-1:0]     tgt_addr, pc_inc, top_addr;
    logic [STACK_LOG2-1:0] push_idx, pop_idx;

    logic                  q_empty, comp_adv, src_valid, src_exec, src_multi, pop;
    logic [31:0]           q_head, src_insn, issue_word, rem_word;
    logic [14:0]           src_count;

    assign flush       = start || abort;
    assign running     = (state == ST_RUN);
    assign rsp_fire    = smem_valid && smem_ready && !flush;
    assign is_call     = (smem_data[5:0] == OP_CALL);
    assign is_ret      = (smem_data[5:0] == OP_RET);
    assign is_jump     = (smem_data[5:0] == OP_JUMP);
    assign enq         = rsp_fire && !is_call && !is_ret && !is_jump;
    assign stack_full  = (sp == SPTR_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign tgt_addr    = ADDR_W'({smem_data[31:17], 1'b0});
    assign pc_inc      = pc + ADDR_W'(2);
    assign push_idx    = STACK_LOG2'(sp);
    assign pop_idx     = STACK_LOG2'(sp - SPTR_W'(1));
    assign top_addr    = stack_mem[pop_idx];

    // Run state: start wins over abort; a program ends on overflow or on return from top level
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start)
            state_next = ST_RUN;
        else if (abort)
            state_next = ST_IDLE;
        else if (rsp_fire && ((is_call && stack_full) || (is_ret && stack_empty)))
            state_next = ST_IDLE;
    end

    // Front-end: single outstanding fetch, control flow resolved on the response
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc         <= '0;
            sp         <= '0;
            error      <= 1'b0;
            smem_valid <= 1'b0;
            smem_addr  <= '0;
        end else if (start) begin
            pc         <= addr;
            sp         <= '0;
            error      <= 1'b0;
            smem_valid <= 1'b0;
        end else if (abort) begin
            sp         <= '0;
            smem_valid <= 1'b0;
        end else if (smem_valid) begin
            if (smem_ready) begin
                smem_valid <= 1'b0;
                if (is_call) begin
                    if (stack_full) begin
                        error <= 1'b1;
                    end else begin
                        sp <= sp + SPTR_W'(1);
                        pc <= tgt_addr;
                    end
                end else if (is_ret) begin
                    if (!stack_empty) begin
                        sp <= sp - SPTR_W'(1);
                        pc <= top_addr;
                    end
                end else if (is_jump) begin
                    pc <= tgt_addr;
                end else begin
                    pc <= pc_inc;
                end
            end
        end else if (running && !queue_full && !error) begin
            smem_valid <= 1'b1;
            smem_addr  <= pc;
        end
    end

    always_ff @(posedge clock) begin
        if (rsp_fire && is_call && !stack_full)
            stack_mem[push_idx] <= pc_inc;
    end

    assign q_count = wr_ptr - rd_ptr;
    assign q_empty = (q_count == '0);
    assign q_head  = q_mem[QUEUE_LOG2'(rd_ptr)];

    always_ff @(posedge clock) begin
        if (enq)
            q_mem[QUEUE_LOG2'(wr_ptr)] <= smem_data;
    end

    // FIFO pointers; queue_full lags occupancy by a cycle, covered by the margin
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            queue_full <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            queue_full <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + QPTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + QPTR_W'(1);
            queue_full <= (q_count >= QPTR_W'(QUEUE_LIMIT));
        end
    end

    // Back-end source: pending expansion remainder first, else the FIFO head
    assign comp_adv   = !comp_valid || comp_ready;
    assign src_valid  = buf_valid || !q_empty;
    assign src_insn   = buf_valid ? buf_insn : q_head;
    assign src_exec   = (src_insn[5:0] == OP_EXEC);
    assign src_count  = src_insn[31:17];
    assign src_multi  = src_exec && (src_count > 15'd1);
    assign issue_word = src_exec ? {15'd1, src_insn[16:0]} : src_insn;
    assign rem_word   = {src_count - 15'd1, src_insn[16:6] + 11'd1, src_insn[5:0]};
    assign pop        = comp_adv && !buf_valid && !q_empty && !flush;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            buf_insn   <= '0;
            buf_valid  <= 1'b0;
            comp_valid <= 1'b0;
            comp_data  <= '0;
        end else if (flush) begin
            buf_valid  <= 1'b0;
            comp_valid <= 1'b0;
        end else if (comp_adv) begin
            comp_valid <= src_valid;
            if (src_valid) begin
                comp_data <= issue_word;
                buf_valid <= src_multi;
                if (src_multi)
                    buf_insn <= rem_word;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) busy <= 1'b0;
        else         busy <= start || running || !q_empty || buf_valid || comp_valid;
    end

`ifdef MLACCEL_SEQ_STATS_EN
    // Saturating count of compute-port handshakes
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            stat_issued <= '0;
        else if (start)
            stat_issued <= '0;
        else if (comp_valid && comp_ready && (stat_issued != 32'hFFFF_FFFF))
            stat_issued <= stat_issued + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mlaccel_sequencer_gen2.sv
// Scoreboard bench for mlaccel_sequencer_gen2: a memory responder and compute sink run
// in the background; each scenario task drives a program and checks its own outcome.
`timescale 1ns/1ps
module tb_mlaccel_sequencer_gen2;

    localparam int unsigned ADDR_W = 16;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              busy, error, smem_valid, comp_valid;
    logic              smem_ready = 1'b0;
    logic              comp_ready = 1'b0;
    logic [ADDR_W-1:0] smem_addr;
    logic [31:0]       smem_data = '0;
    logic [31:0]       comp_data;
`ifdef MLACCEL_SEQ_STATS_EN
    logic [31:0]       stat_issued;
`endif

    mlaccel_sequencer_gen2 #(
        .ADDR_W(16), .QUEUE_LOG2(9), .STACK_LOG2(2), .QUEUE_MARGIN(16)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort), .addr(addr),
        .busy(busy), .error(error),
        .smem_valid(smem_valid), .smem_ready(smem_ready), .smem_addr(smem_addr),
        .smem_data(smem_data),
        .comp_valid(comp_valid), .comp_ready(comp_ready), .comp_data(comp_data)
`ifdef MLACCEL_SEQ_STATS_EN
        , .stat_issued(stat_issued)
`endif
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:32767];
    logic [31:0] exp_q [$];
    logic [15:0] addr_log [$];
    int          checks = 0, errors = 0;
    int          delivered = 0, supplied = 0, fetches = 0;
    bit          resp_en = 1'b0, hold = 1'b0, rand_comp = 1'b0, rand_smem = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    // Memory responder and compute sink; expectations are pushed as words are supplied
    initial begin : agents
        logic [31:0] w, e;
        logic [10:0] a;
        int          n;
        forever begin
            @(negedge clock);
            if (resp_en && smem_valid === 1'b1 && (!rand_smem || $urandom_range(0, 3) != 0)) begin
                w = mem[smem_addr[15:1]];
                smem_ready = 1'b1;
                smem_data  = w;
                addr_log.push_back(smem_addr);
                fetches++;
                if (w[5:0] == 6'd3) begin
                    n = (w[31:17] == 15'd0) ? 1 : int'(w[31:17]);
                    a = w[16:6];
                    for (int k = 0; k < n; k++) begin
                        exp_q.push_back({15'd1, a, w[5:0]});
                        a = a + 11'd1;
                    end
                    supplied++;
                end else if (w[5:0] != 6'd1 && w[5:0] != 6'd2 && w[5:0] != 6'd4) begin
                    exp_q.push_back(w);
                    supplied++;
                end
            end else begin
                smem_ready = 1'b0;
                smem_data  = $urandom;
            end

            if (prev_stall) begin
                checks++;
                if (comp_valid !== 1'b1 || comp_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                             comp_valid, comp_data, prev_data);
                end
            end
            comp_ready = hold ? 1'b0 : (rand_comp ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (comp_valid === 1'b1 && comp_ready) begin
                delivered++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL comp_order: got %h, required no output (nothing pending)", comp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (comp_data !== e) begin
                        errors++;
                        $display("FAIL comp_order: got %h, required %h", comp_data, e);
                    end
                end
            end
            prev_stall = (comp_valid === 1'b1) && !comp_ready;
            prev_data  = comp_data;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_start(input logic [15:0] a);
        resp_en = 1'b0;
        start   = 1'b1;
        addr    = a;
        exp_q.delete();
        addr_log.delete();
        delivered  = 0;
        supplied   = 0;
        fetches    = 0;
        prev_stall = 1'b0;
        tick();
        start   = 1'b0;
        resp_en = 1'b1;
    endtask

    task automatic do_abort();
        hold    = 1'b1;
        resp_en = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        hold    = 1'b0;
        resp_en = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_in_reset: got %b, required 0", busy); end
        resetn = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, required 0", error); end
        checks++;
        if (smem_valid !== 1'b0) begin errors++; $display("FAIL reset_smem_valid: got %b, required 0", smem_valid); end
        checks++;
        if (smem_addr !== 16'h0) begin errors++; $display("FAIL reset_smem_addr: got %h, required 0000", smem_addr); end
        checks++;
        if (comp_valid !== 1'b0) begin errors++; $display("FAIL reset_comp_valid: got %b, required 0", comp_valid); end
        checks++;
        if (comp_data !== 32'h0) begin errors++; $display("FAIL reset_comp_data: got %h, required 0", comp_data); end
`ifdef MLACCEL_SEQ_STATS_EN
        checks++;
        if (stat_issued !== 32'h0) begin errors++; $display("FAIL reset_stat: got %0d, required 0", stat_issued); end
`endif
    endtask

    task automatic test_exec_expand();
        rand_comp = 1'b1;
        rand_smem = 1'b1;
        mem[16'h0080] = {15'd3, 11'd5, 6'd3};
        mem[16'h0081] = 32'd2;
        do_start(16'h0100);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL exec_busy_rise: got %b, required 1", busy); end
        for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL exec_busy_fall: got %b, required 0 (timeout)", busy); end
        checks++;
        if (delivered != 3) begin errors++; $display("FAIL exec_count: got %0d, required 3", delivered); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL exec_pending: got %0d, required 0", exp_q.size()); end
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL exec_error: got %b, required 0", error); end
    endtask

    task automatic test_call_return();
        logic [15:0] exp_addr [5];
        logic [15:0] got;
        exp_addr = '{16'h0000, 16'h0200, 16'h0202, 16'h0002, 16'h0004};
        mem[16'h0000] = {15'h100, 11'd0, 6'd1};
        mem[16'h0001] = 32'h1234_5000;
        mem[16'h0002] = 32'd2;
        mem[16'h0100] = {15'd1, 11'd9, 6'd3};
        mem[16'h0101] = 32'd2;
        do_start(16'h0000);
        for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL call_busy_fall: got %b, required 0 (timeout)", busy); end
        checks++;
        if (delivered != 2) begin errors++; $display("FAIL call_count: got %0d, required 2", delivered); end
        checks++;
        if (addr_log.size() != 5) begin errors++; $display("FAIL call_nfetch: got %0d, required 5", addr_log.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < addr_log.size()) ? addr_log[i] : 16'hxxxx;
            checks++;
            if (got !== exp_addr[i]) begin
                errors++;
                $display("FAIL call_fetch_addr[%0d]: got %h, required %h", i, got, exp_addr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int f_mark, occ;
        rand_comp = 1'b0;
        rand_smem = 1'b0;
        for (int i = 0; i < 600; i++) mem[16'h0800 + i] = {26'(i + 1), 6'd0};
        mem[16'h0800 + 600] = 32'd2;
        do_start(16'h1000);
        repeat (5) tick();
        hold = 1'b1;
        repeat (1150) tick();
        f_mark = fetches;
        repeat (50) tick();
        checks++;
        if (fetches != f_mark) begin errors++; $display("FAIL bp_fetch_stall: got %0d fetches, required %0d", fetches, f_mark); end
        occ = supplied - delivered - 1;
        checks++;
        if (occ < 496 || occ > 497) begin errors++; $display("FAIL bp_occupancy: got %0d, required 496..497", occ); end
        checks++;
        if (comp_valid !== 1'b1) begin errors++; $display("FAIL bp_comp_valid: got %b, required 1", comp_valid); end
        hold = 1'b0;
        for (int i = 0; i < 4000 && busy !== 1'b0; i++) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_fall: got %b, required 0 (timeout)", busy); end
        checks++;
        if (delivered != 600) begin errors++; $display("FAIL bp_count: got %0d, required 600", delivered); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_pending: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_stack_overflow();
        rand_comp = 1'b1;
        rand_smem = 1'b1;
        mem[16'h0180] = {15'h180, 11'd0, 6'd1};
        do_start(16'h0300);
        for (int i = 0; i < 300 && error !== 1'b1; i++) tick();
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b, required 1 (timeout)", error); end
        checks++;
        if (fetches != 5) begin errors++; $display("FAIL ovf_fetches: got %0d, required 5", fetches); end
        for (int i = 0; i < 50 && busy !== 1'b0; i++) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_fall: got %b, required 0", busy); end
        checks++;
        if (smem_valid !== 1'b0 || fetches != 5) begin
            errors++;
            $display("FAIL ovf_fetch_stop: smem_valid=%b fetches=%0d, required 0 and 5", smem_valid, fetches);
        end
        do_start(16'h0100);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL ovf_error_clear: got %b, required 0", error); end
        for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
        checks++;
        if (delivered != 3) begin errors++; $display("FAIL ovf_rerun_count: got %0d, required 3", delivered); end
    endtask

    task automatic test_abort();
        rand_comp = 1'b1;
        rand_smem = 1'b1;
        mem[16'h1000] = {15'd100, 11'h010, 6'd3};
        mem[16'h1001] = 32'd2;
        do_start(16'h2000);
        for (int i = 0; i < 300 && delivered < 10; i++) tick();
        checks++;
        if (delivered < 10) begin errors++; $display("FAIL abort_progress: got %0d, required >=10", delivered); end
        do_abort();
        checks++;
        if (comp_valid !== 1'b0) begin errors++; $display("FAIL abort_comp_valid: got %b, required 0", comp_valid); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
        for (int i = 0; i < 3; i++) mem[16'h1800 + i] = 32'hC0DE_0000 | (32'(i + 1) << 6);
        mem[16'h1803] = 32'd2;
        do_start(16'h3000);
        for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
        checks++;
        if (delivered != 3) begin errors++; $display("FAIL abort_restart_count: got %0d, required 3", delivered); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL abort_restart_pending: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_jump_loop();
        rand_comp = 1'b1;
        rand_smem = 1'b1;
        mem[16'h2000] = {15'd0, 11'h7FF, 6'd3};
        mem[16'h2001] = {15'd2, 11'h7FF, 6'd3};
        mem[16'h2002] = {15'h2000, 11'd0, 6'd4};
        do_start(16'h4000);
`ifdef MLACCEL_SEQ_STATS_EN
        checks++;
        if (stat_issued !== 32'd0) begin errors++; $display("FAIL jump_stat_clear: got %0d, required 0", stat_issued); end
`endif
        repeat (300) tick();
        do_abort();
        checks++;
        if (delivered < 20) begin errors++; $display("FAIL jump_progress: got %0d, required >=20", delivered); end
        checks++;
        if (fetches < 6 || addr_log[3] !== 16'h4000) begin
            errors++;
            $display("FAIL jump_refetch: fetches=%0d addr_log[3]=%h, required >=6 and 4000",
                     fetches, (addr_log.size() > 3) ? addr_log[3] : 16'hxxxx);
        end
`ifdef MLACCEL_SEQ_STATS_EN
        checks++;
        if (stat_issued !== 32'(delivered)) begin
            errors++;
            $display("FAIL jump_stat: got %0d, required %0d", stat_issued, delivered);
        end
`endif
    endtask

    initial begin : main
        for (int i = 0; i < 32768; i++) mem[i] = 32'd2;
        test_reset();
        test_exec_expand();
        test_call_return();
        test_backpressure();
        test_stack_overflow();
        test_abort();
        test_jump_loop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
